// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding core request, byte-lane steering, load extension,
// alignment/funct3 checking and a bounded wait on a wait-stated data memory.
//
// state  | meaning
// IDLE   | ready for a core request; errors are decided here without touching memory
// ACCESS | mem_req held with stable address/lanes until mem_ack or timeout
// RESP   | one-cycle rsp_valid with registered rsp_rdata/rsp_err
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                stall,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata
);
  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state, state_next;
  logic [2:0]         funct3_q;
  logic [OFF_W-1:0]   off_q;
  logic               we_q;
  logic [CNT_W-1:0]   cnt;

  logic               accept, legal, misaligned, timeout_hit;
  logic [1:0]         req_err;
  logic [BE_W-1:0]    be_d;
  logic [XLEN-1:0]    wdata_d, lane, load_ext;
  logic [OFF_W-1:0]   req_off;

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_ready = (state == IDLE) & reset;
  assign accept    = req_valid & req_ready;
  assign stall     = req_valid & ~rsp_valid;
  assign mem_we    = we_q & (state == ACCESS);

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b011:                 legal = (XLEN == 64);
      3'b100, 3'b101:         legal = !req_write;
      3'b110:                 legal = !req_write && (XLEN == 64);
      default:                legal = 1'b0;
    endcase
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
    // An illegal funct3 masks any alignment complaint.
    if (!legal)          req_err = 2'b10;
    else if (misaligned) req_err = 2'b01;
    else                 req_err = 2'b00;
  end

  always_comb begin
    be_d    = '1;
    wdata_d = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_d    = BE_W'(1) << req_off;
        wdata_d = {BE_W{req_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = BE_W'(3) << req_off;
        wdata_d = {(XLEN/16){req_wdata[15:0]}};
      end
      2'b10: begin
        be_d    = BE_W'(15) << req_off;
        wdata_d = {(XLEN/32){req_wdata[31:0]}};
      end
      default: begin
        be_d    = '1;
        wdata_d = req_wdata;
      end
    endcase
  end

  assign lane = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = '0;
    case (funct3_q)
      3'b000:  load_ext = XLEN'($signed(lane[7:0]));
      3'b001:  load_ext = XLEN'($signed(lane[15:0]));
      3'b010:  load_ext = XLEN'($signed(lane[31:0]));
      3'b011:  load_ext = lane;
      3'b100:  load_ext = XLEN'(lane[7:0]);
      3'b101:  load_ext = XLEN'(lane[15:0]);
      3'b110:  load_ext = XLEN'(lane[31:0]);
      default: load_ext = '0;
    endcase
  end

  // Cycle n of ACCESS sees cnt == n-1, so the last permitted cycle is cnt == TIMEOUT-1.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = (req_err != 2'b00) ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_req = 1'b1;
        if (mem_ack || timeout_hit) state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      funct3_q  <= '0;
      off_q     <= '0;
      we_q      <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            funct3_q  <= req_funct3;
            off_q     <= req_off;
            we_q      <= req_write;
            cnt       <= '0;
            mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_be    <= be_d;
            mem_wdata <= wdata_d;
            if (req_err != 2'b00) begin
              rsp_err   <= req_err;
              rsp_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            rsp_err   <= 2'b00;
            rsp_rdata <= we_q ? '0 : load_ext;
          end else begin
            if (timeout_hit) begin
              rsp_err   <= 2'b11;
              rsp_rdata <= '0;
            end
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (XLEN=32, TIMEOUT=4): directed scenarios plus
// randomized back-to-back transactions against a byte-level reference model.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_write, stall, rsp_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  rsp_err;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          req_cycles;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        mwe;
    bit          unstable;
    bit          stall_bad;
    bit          ready;
    bit          rsp_after;
    bit          held_ok;
    bit          ready_after;
  } obs_t;

  typedef struct {
    int          lat;
    int          req_cycles;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        mwe;
  } exp_t;

  // Reference: accesses described as (size, offset, signedness) over byte lanes.
  function automatic exp_t model(bit wr, logic [2:0] f3, logic [31:0] addr,
                                 logic [31:0] wd, logic [31:0] word, int ack_at);
    exp_t e;
    int size, off;
    bit legal, sgn;
    longint val;
    e = '{default: '0};
    case (f3)
      3'd0: begin size = 1; sgn = 1; legal = 1; end
      3'd1: begin size = 2; sgn = 1; legal = 1; end
      3'd2: begin size = 4; sgn = 1; legal = 1; end
      3'd4: begin size = 1; sgn = 0; legal = !wr; end
      3'd5: begin size = 2; sgn = 0; legal = !wr; end
      default: begin size = 1; sgn = 0; legal = 0; end
    endcase
    off = int'(addr % 4);
    if (!legal) begin
      e.err = 2'd2; e.lat = 1;
    end else if ((addr % size) != 0) begin
      e.err = 2'd1; e.lat = 1;
    end else begin
      e.maddr = addr - off;
      e.mwe   = wr;
      for (int i = 0; i < 4; i++) begin
        e.be[i] = (i >= off) && (i < off + size);
        e.mwdata[8*i +: 8] = wd[8*(i % size) +: 8];
      end
      if (ack_at >= 1 && ack_at <= TO) begin
        e.lat = ack_at + 1; e.req_cycles = ack_at; e.err = 2'd0;
        if (!wr) begin
          val = 0;
          for (int j = 0; j < size; j++) val += longint'(word[8*(off+j) +: 8]) << (8*j);
          if (sgn && val >= (64'sd1 << (8*size - 1))) val -= (64'sd1 << (8*size));
          e.rdata = val[31:0];
        end
      end else begin
        e.lat = TO + 1; e.req_cycles = TO; e.err = 2'd3;
      end
    end
    return e;
  endfunction

  // Drives one request from a falling edge with IDLE state; memory acks in ACCESS cycle
  // ack_at (0 = never). Returns at the falling edge after the response cycle.
  task automatic run_txn(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] word, input int ack_at,
                         output obs_t o);
    int cyc;
    bit done;
    o = '{default: '0};
    o.ready = req_ready;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk); cyc++;
      if (mem_req) begin
        o.req_cycles++;
        if (o.req_cycles == 1) begin
          o.be = mem_be; o.maddr = mem_addr; o.mwdata = mem_wdata; o.mwe = mem_we;
        end else if (mem_be !== o.be || mem_addr !== o.maddr || mem_wdata !== o.mwdata ||
                     mem_we !== o.mwe) o.unstable = 1;
      end
      if (rsp_valid) begin
        if (stall !== 1'b0) o.stall_bad = 1;
        o.lat = cyc; o.err = rsp_err; o.rdata = rsp_rdata; done = 1;
        req_valid = 1'b0; mem_ack = 1'b0;
      end else begin
        if (stall !== 1'b1) o.stall_bad = 1;
        mem_ack   = mem_req && (o.req_cycles == ack_at);
        mem_rdata = mem_ack ? word : $urandom();
      end
    end
    if (!done) begin
      o.lat = -1; req_valid = 1'b0; mem_ack = 1'b0;
    end
    @(negedge clk);
    o.rsp_after   = rsp_valid;
    o.held_ok     = (rsp_err === o.err) && (rsp_rdata === o.rdata);
    o.ready_after = req_ready;
  endtask

  task automatic test_reset();
    req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_ack = 0; mem_rdata = 0; reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, mem_req, mem_we, rsp_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {req_ready, mem_req, mem_we, rsp_valid});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_be, rsp_rdata, rsp_err} !== '0) begin
      errors++; $display("FAIL reset_data: got addr=%h wd=%h be=%h rd=%h err=%b want all 0",
                         mem_addr, mem_wdata, mem_be, rsp_rdata, rsp_err);
    end
    reset = 1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_lw_zero_wait();
    obs_t o;
    run_txn(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, o);
    checks++; if (o.be !== 4'hF) begin errors++; $display("FAIL lw_be: got %h want f", o.be); end
    checks++; if (o.maddr !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h want 100", o.maddr); end
    checks++; if (o.lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", o.lat); end
    checks++; if (o.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h want deadbeef", o.rdata); end
    checks++; if (o.err !== 2'b00) begin errors++; $display("FAIL lw_err: got %b want 00", o.err); end
    checks++; if (o.rsp_after !== 1'b0) begin errors++; $display("FAIL lw_pulse_width: got %b want 0", o.rsp_after); end
  endtask

  task automatic test_byte_loads();
    obs_t o;
    run_txn(0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, o);
    checks++; if (o.be !== 4'h8) begin errors++; $display("FAIL lb_be: got %h want 8", o.be); end
    checks++; if (o.rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", o.rdata); end
    run_txn(0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 2, o);
    checks++; if (o.rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata: got %h want 00000080", o.rdata); end
  endtask

  task automatic test_half_store();
    obs_t o;
    run_txn(1, 3'b001, 32'h206, 32'h1234ABCD, 32'hFFFFFFFF, 4, o);
    checks++; if (o.mwe !== 1'b1) begin errors++; $display("FAIL sh_we: got %b want 1", o.mwe); end
    checks++; if (o.maddr !== 32'h204) begin errors++; $display("FAIL sh_addr: got %h want 204", o.maddr); end
    checks++; if (o.be !== 4'hC) begin errors++; $display("FAIL sh_be: got %h want c", o.be); end
    checks++; if (o.mwdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcdabcd", o.mwdata); end
    checks++; if (o.req_cycles !== 4) begin errors++; $display("FAIL sh_req_cycles: got %0d want 4", o.req_cycles); end
    checks++; if (o.lat !== 5) begin errors++; $display("FAIL sh_latency: got %0d want 5", o.lat); end
    checks++; if (o.rdata !== 32'h0 || o.err !== 2'b00) begin
      errors++; $display("FAIL sh_rsp: got rd=%h err=%b want 0/00", o.rdata, o.err);
    end
    checks++; if (o.unstable) begin errors++; $display("FAIL sh_stable: got changing mem outputs want stable"); end
  endtask

  task automatic test_errors();
    obs_t o;
    run_txn(0, 3'b001, 32'h101, 32'h0, 32'h0, 1, o);
    checks++; if (o.err !== 2'b01 || o.lat !== 1) begin
      errors++; $display("FAIL lh_misaligned: got err=%b lat=%0d want 01/1", o.err, o.lat);
    end
    checks++; if (o.req_cycles !== 0) begin errors++; $display("FAIL lh_no_mem: got %0d mem cycles want 0", o.req_cycles); end
    run_txn(0, 3'b111, 32'h101, 32'h0, 32'h0, 1, o);
    checks++; if (o.err !== 2'b10 || o.req_cycles !== 0) begin
      errors++; $display("FAIL f3_111: got err=%b cyc=%0d want 10/0", o.err, o.req_cycles);
    end
    run_txn(1, 3'b011, 32'h100, 32'h0, 32'h0, 1, o);
    checks++; if (o.err !== 2'b10 || o.rdata !== 32'h0) begin
      errors++; $display("FAIL f3_011_rv32: got err=%b rd=%h want 10/0", o.err, o.rdata);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(0, 3'b010, 32'h40, 32'h0, 32'h12345678, 0, o);
    checks++; if (o.req_cycles !== TO) begin errors++; $display("FAIL to_req_cycles: got %0d want %0d", o.req_cycles, TO); end
    checks++; if (o.lat !== TO + 1 || o.err !== 2'b11) begin
      errors++; $display("FAIL to_rsp: got lat=%0d err=%b want %0d/11", o.lat, o.err, TO + 1);
    end
    run_txn(0, 3'b010, 32'h40, 32'h0, 32'h12345678, TO, o);
    checks++; if (o.err !== 2'b00 || o.rdata !== 32'h12345678 || o.lat !== TO + 1) begin
      errors++; $display("FAIL to_ack_wins: got err=%b rd=%h lat=%0d want 00/12345678/%0d", o.err, o.rdata, o.lat, TO + 1);
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    exp_t e;
    bit saw;
    logic [31:0] w;
    req_valid = 1; req_write = 0; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_access_req: got %b want 1", mem_req); end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++; if ({mem_req, rsp_valid, req_ready} !== 3'b000) begin
      errors++; $display("FAIL mid_reset_drop: got req/rsp/ready=%b want 000", {mem_req, rsp_valid, req_ready});
    end
    req_valid = 0; reset = 1; mem_ack = 1; mem_rdata = 32'h55555555;
    saw = 0;
    repeat (3) begin @(negedge clk); if (rsp_valid !== 1'b0 || mem_req !== 1'b0) saw = 1; end
    mem_ack = 0;
    checks++; if (saw) begin errors++; $display("FAIL late_ack_ignored: got activity want none"); end
    w = $urandom();
    run_txn(0, 3'b010, 32'h304, 32'h0, w, 2, o);
    e = model(0, 3'b010, 32'h304, 32'h0, w, 2);
    checks++; if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
      errors++; $display("FAIL post_reset_lw: got lat=%0d rd=%h err=%b want %0d/%h/%b", o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    bit wr;
    logic [2:0] f3;
    logic [31:0] addr, wd, word;
    int ack_at;
    for (int n = 0; n < 80; n++) begin
      wr = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      addr = 32'h1000 + $urandom_range(0, 63); wd = $urandom(); word = $urandom();
      ack_at = $urandom_range(0, TO + 2);
      run_txn(wr, f3, addr, wd, word, ack_at, o);
      e = model(wr, f3, addr, wd, word, ack_at);
      checks++;
      if (o.lat !== e.lat || o.req_cycles !== e.req_cycles || o.err !== e.err || o.rdata !== e.rdata) begin
        errors++; $display("FAIL rand_rsp[%0d]: got lat=%0d cyc=%0d err=%b rd=%h want %0d/%0d/%b/%h",
                           n, o.lat, o.req_cycles, o.err, o.rdata, e.lat, e.req_cycles, e.err, e.rdata);
      end
      if (e.req_cycles > 0) begin
        checks++;
        if (o.be !== e.be || o.maddr !== e.maddr || o.mwe !== e.mwe || (wr && o.mwdata !== e.mwdata) || o.unstable) begin
          errors++; $display("FAIL rand_mem[%0d]: got be=%h a=%h we=%b wd=%h unst=%0d want %h/%h/%b/%h/0",
                             n, o.be, o.maddr, o.mwe, o.mwdata, o.unstable, e.be, e.maddr, e.mwe, e.mwdata);
        end
      end
      checks++;
      if (o.stall_bad || !o.ready || o.rsp_after || !o.held_ok || !o.ready_after) begin
        errors++; $display("FAIL rand_handshake[%0d]: got stall_bad=%0d ready=%0d rsp_after=%0d held=%0d ready_after=%0d want 0/1/0/1/1",
                           n, o.stall_bad, o.ready, o.rsp_after, o.held_ok, o.ready_after);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_zero_wait();
    test_byte_loads();
    test_half_store();
    test_errors();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
